// File: rtl/sm4_pkg.sv
// sm4_pkg: SM4 constants and helpers (S-box, FK, CK, rotate) shared by the key schedule and the cipher core.
package sm4_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [7:0] SBOX [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };
  function automatic logic [31:0] sm4_sbox32(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction
  // byte j of CK_i is (4i+j)*7 mod 256, MSB first; truncation to 8 bits is the mod
  function automatic logic [31:0] sm4_ck(input logic [4:0] i);
    logic [31:0] ck;
    ck = '0;
    for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'((({27'd0, i} << 2) + 32'(j)) * 32'd7)};
    return ck;
  endfunction
endpackage

// File: rtl/sm4_tprime.sv
// sm4_tprime: key-schedule T' transform, bytewise S-box followed by L'(B) = B ^ B<<<13 ^ B<<<23.
module sm4_tprime
  import sm4_pkg::*;
(
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  logic [31:0] b;
  assign b = sm4_sbox32(x_i);
  assign y_o = b ^ rotl32(b, 13) ^ rotl32(b, 23);
endmodule

// File: rtl/sm4_keyexp.sv
// sm4_keyexp: iterative SM4 key expansion, one round key per clock packed into a 1024-bit bus.
module sm4_keyexp
  import sm4_pkg::*;
(
  input  logic          CLK_i,
  input  logic          RST_N_i,
  input  logic [127:0]  KEY_i,
  input  logic          DEC_i,
  input  logic          KEY_VALID_i,
  output logic [1023:0] RK_o,
  output logic          RK_VALID_o,
  output logic          BUSY_o
);
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [127:0] k_q, k_d;
  logic dec_q, dec_d;
  logic [1023:0] rk_q, rk_d;
  logic valid_q, valid_d, busy_q, busy_d;
  logic [31:0] tp, rk;
  logic accept;
  sm4_tprime u_tprime (
    .x_i(k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ sm4_ck(cnt_q)),
    .y_o(tp)
  );
  assign rk = k_q[127:96] ^ tp;
  assign accept = KEY_VALID_i && state_q != ST_RUN;
  // k_q holds the sliding window K0..K3 with K0 in the top word
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    k_d = k_q;
    dec_d = dec_q;
    rk_d = rk_q;
    valid_d = valid_q;
    if (accept) begin
      state_d = ST_RUN;
      cnt_d = '0;
      k_d = KEY_i ^ FK;
      dec_d = DEC_i;
      rk_d = '0;
      valid_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q + 5'd1;
      k_d = {k_q[95:0], rk};
      rk_d = dec_q ? {rk, rk_q[1023:32]} : {rk_q[991:0], rk};
      state_d = cnt_q == 5'd31 ? ST_DONE : ST_RUN;
      valid_d = cnt_q == 5'd31;
    end
    busy_d = state_d == ST_RUN;
  end
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      k_q <= '0;
      dec_q <= 1'b0;
      rk_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      dec_q <= dec_d;
      rk_q <= rk_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign RK_o = rk_q;
  assign RK_VALID_o = valid_q;
  assign BUSY_o = busy_q;
endmodule

// File: tb/tb_sm4_keyexp.sv
// tb_sm4_keyexp: randomized and known-answer bench for sm4_keyexp against an array-based key schedule and cipher model.
module tb_sm4_keyexp;
  logic CLK_i, RST_N_i, DEC_i, KEY_VALID_i, RK_VALID_o, BUSY_o;
  logic [127:0] KEY_i;
  logic [1023:0] RK_o;
  int passed = 0, total = 0;
  localparam logic [127:0] KAT_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KAT_CT = 128'h681EDF34D206965E86B3E94F536E4246;
  localparam logic [127:0] FKV = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  logic [1023:0] enc_rk;

  sm4_keyexp dut (
    .CLK_i(CLK_i), .RST_N_i(RST_N_i), .KEY_i(KEY_i), .DEC_i(DEC_i),
    .KEY_VALID_i(KEY_VALID_i), .RK_o(RK_o), .RK_VALID_o(RK_VALID_o), .BUSY_o(BUSY_o)
  );

  initial CLK_i = 1'b0;
  always #5 CLK_i = ~CLK_i;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] sub(input logic [31:0] x);
    logic [31:0] y;
    for (int j = 0; j < 4; j++) y[8*j +: 8] = sm4_pkg::SBOX[x[8*j +: 8]];
    return y;
  endfunction

  function automatic logic [31:0] ck_of(input int i);
    logic [31:0] c;
    for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
    return c;
  endfunction

  function automatic logic [1023:0] model_rk(input logic [127:0] key, input logic dec);
    logic [31:0] k [36];
    logic [31:0] b;
    logic [1023:0] r;
    for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32] ^ FKV[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      b = sub(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_of(i));
      k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
    end
    for (int i = 0; i < 32; i++)
      if (dec) r[32*i +: 32] = k[i+4];
      else r[1023-32*i -: 32] = k[i+4];
    return r;
  endfunction

  function automatic logic [127:0] crypt(input logic [127:0] d, input logic [1023:0] rks);
    logic [31:0] x [36];
    logic [31:0] b;
    for (int i = 0; i < 4; i++) x[i] = d[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      b = sub(x[i+1] ^ x[i+2] ^ x[i+3] ^ rks[1023-32*i -: 32]);
      x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge CLK_i);
    #1;
  endtask

  task automatic request(input logic [127:0] key, input logic dec);
    KEY_i = key;
    DEC_i = dec;
    KEY_VALID_i = 1'b1;
    step();
    KEY_VALID_i = 1'b0;
    KEY_i = rnd128();
    DEC_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat, output logic bok);
    lat = 0;
    bok = 1'b1;
    while (!RK_VALID_o && lat < 40) begin
      if (!BUSY_o) bok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    RST_N_i = 1'b0;
    KEY_VALID_i = 1'b0;
    KEY_i = '0;
    DEC_i = 1'b0;
    repeat (2) step();
    total++; if (RK_o !== '0) $display("FAIL reset_rk: got %h want 0", RK_o); else passed++;
    total++; if (RK_VALID_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", RK_VALID_o); else passed++;
    total++; if (BUSY_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY_o); else passed++;
    #2 RST_N_i = 1'b1;
    step();
  endtask

  task automatic test_kat_enc();
    int lat;
    logic bok;
    enc_rk = model_rk(KAT_KEY, 1'b0);
    request(KAT_KEY, 1'b0);
    wait_valid(lat, bok);
    total++; if (lat !== 32) $display("FAIL enc_latency: got %0d want 32", lat); else passed++;
    total++; if (bok !== 1'b1) $display("FAIL enc_busy_run: got %b want 1", bok); else passed++;
    total++; if (BUSY_o !== 1'b0) $display("FAIL enc_busy_done: got %b want 0", BUSY_o); else passed++;
    total++; if (RK_o !== enc_rk) $display("FAIL enc_rk: got %h want %h", RK_o, enc_rk); else passed++;
    total++; if (RK_o[1023:992] !== 32'hF12186F9) $display("FAIL enc_rk0: got %h want f12186f9", RK_o[1023:992]); else passed++;
    total++; if (RK_o[31:0] !== 32'h9124A012) $display("FAIL enc_rk31: got %h want 9124a012", RK_o[31:0]); else passed++;
    total++; if (crypt(KAT_KEY, RK_o) !== KAT_CT) $display("FAIL enc_cipher: got %h want %h", crypt(KAT_KEY, RK_o), KAT_CT); else passed++;
    repeat (5) step();
    total++; if (RK_o !== enc_rk || RK_VALID_o !== 1'b1) $display("FAIL enc_hold: got %h/%b want %h/1", RK_o, RK_VALID_o, enc_rk); else passed++;
  endtask

  task automatic test_kat_dec();
    int lat;
    logic bok;
    logic [1023:0] rev;
    for (int i = 0; i < 32; i++) rev[32*i +: 32] = enc_rk[1023-32*i -: 32];
    request(KAT_KEY, 1'b1);
    wait_valid(lat, bok);
    total++; if (lat !== 32) $display("FAIL dec_latency: got %0d want 32", lat); else passed++;
    total++; if (RK_o[31:0] !== 32'hF12186F9) $display("FAIL dec_rk0: got %h want f12186f9", RK_o[31:0]); else passed++;
    total++; if (RK_o[1023:992] !== 32'h9124A012) $display("FAIL dec_rk31: got %h want 9124a012", RK_o[1023:992]); else passed++;
    total++; if (RK_o !== rev) $display("FAIL dec_reversed: got %h want %h", RK_o, rev); else passed++;
    total++; if (crypt(KAT_CT, RK_o) !== KAT_KEY) $display("FAIL dec_plain: got %h want %h", crypt(KAT_CT, RK_o), KAT_KEY); else passed++;
  endtask

  task automatic test_random();
    int lat;
    logic bok;
    logic [127:0] k;
    logic d;
    logic [1023:0] exp_rk;
    for (int n = 0; n < 4; n++) begin
      k = rnd128();
      d = 1'($urandom_range(0, 1));
      exp_rk = model_rk(k, d);
      request(k, d);
      wait_valid(lat, bok);
      total++; if (lat !== 32) $display("FAIL rand%0d_latency: got %0d want 32", n, lat); else passed++;
      total++; if (RK_o !== exp_rk) $display("FAIL rand%0d_rk: got %h want %h", n, RK_o, exp_rk); else passed++;
    end
  endtask

  task automatic test_ignore_in_run();
    logic [127:0] ka, kb;
    logic bok;
    ka = rnd128();
    kb = ~ka;
    bok = 1'b1;
    request(ka, 1'b0);
    for (int c = 0; c < 32; c++) begin
      KEY_VALID_i = c == 5 || c == 20;
      KEY_i = kb;
      DEC_i = 1'b1;
      if (!BUSY_o) bok = 1'b0;
      step();
    end
    KEY_VALID_i = 1'b0;
    total++; if (bok !== 1'b1) $display("FAIL ignore_busy: got %b want 1", bok); else passed++;
    total++; if (RK_VALID_o !== 1'b1) $display("FAIL ignore_valid: got %b want 1", RK_VALID_o); else passed++;
    total++; if (BUSY_o !== 1'b0) $display("FAIL ignore_busy_done: got %b want 0", BUSY_o); else passed++;
    total++; if (RK_o !== model_rk(ka, 1'b0)) $display("FAIL ignore_rk: got %h want %h", RK_o, model_rk(ka, 1'b0)); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic bok;
    logic [127:0] k;
    request(rnd128(), 1'b0);
    repeat (17) step();
    RST_N_i = 1'b0;
    #1;
    total++; if (RK_o !== '0) $display("FAIL midrst_rk: got %h want 0", RK_o); else passed++;
    total++; if (RK_VALID_o !== 1'b0) $display("FAIL midrst_valid: got %b want 0", RK_VALID_o); else passed++;
    total++; if (BUSY_o !== 1'b0) $display("FAIL midrst_busy: got %b want 0", BUSY_o); else passed++;
    #2 RST_N_i = 1'b1;
    step();
    k = rnd128();
    request(k, 1'b1);
    wait_valid(lat, bok);
    total++; if (lat !== 32) $display("FAIL midrst_latency: got %0d want 32", lat); else passed++;
    total++; if (RK_o !== model_rk(k, 1'b1)) $display("FAIL midrst_rk: got %h want %h", RK_o, model_rk(k, 1'b1)); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [99:0] v, b, ev, eb;
    logic [1023:0] exp_rk;
    KEY_i = rnd128();
    DEC_i = 1'($urandom_range(0, 1));
    exp_rk = model_rk(KEY_i, DEC_i);
    KEY_VALID_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      v[i] = RK_VALID_o;
      b[i] = BUSY_o;
      ev[i] = i % 33 == 32;
      eb[i] = i % 33 != 32;
      if (RK_VALID_o) begin
        total++; if (RK_o !== exp_rk) $display("FAIL b2b_rk@%0d: got %h want %h", i, RK_o, exp_rk); else passed++;
      end
    end
    KEY_VALID_i = 1'b0;
    total++; if (v !== ev) $display("FAIL b2b_valid_pattern: got %h want %h", v, ev); else passed++;
    total++; if (b !== eb) $display("FAIL b2b_busy_pattern: got %h want %h", b, eb); else passed++;
  endtask

  initial begin
    test_reset();
    test_kat_enc();
    test_kat_dec();
    test_random();
    test_ignore_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/sm4_keyexp.md
# sm4_keyexp

Iterative SM4 key-expansion engine. Takes a 128-bit master key and produces the 32 round keys rk0..rk31, one per clock, packed into the 1024-bit round-key bus consumed directly by the `decenc` datapath on its `RK_i` port. Sits immediately upstream of `decenc`. A mode bit selects the packing order, so the same `decenc` core performs encryption or decryption without modification.

## Interface
No parameters (SM4 is fixed at 32 rounds, 32-bit words).
- `CLK_i`  in  1  single clock, rising-edge.
- `RST_N_i`  in  1  asynchronous, active-low reset.
- `KEY_i`  in  128  master key MK0..MK3, MK0 in [127:96].
- `DEC_i`  in  1  0 = encryption order, 1 = decryption (reversed) order; sampled with the key.
- `KEY_VALID_i`  in  1  request; accepted on a rising edge when `BUSY_o`=0.
- `RK_o`  out  1024  packed round keys; stable while `RK_VALID_o`=1.
- `RK_VALID_o`  out  1  level: round-key set complete and stable.
- `BUSY_o`  out  1  expansion in progress; requests ignored.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, `RK_o`=0, `RK_VALID_o`=0, `BUSY_o`=0, round counter=0, K registers=0.
- IDLE/DONE with `KEY_VALID_i`=1 → accept:
  - K0..K3 ← MKi ^ FKi, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - latch `DEC_i`; counter←0; `RK_VALID_o`←0; `RK_o`←0; state→RUN.
- RUN, each cycle with counter i:
  - T = K1^K2^K3^CKi.
  - B = Sbox applied bytewise to T.
  - rk = K0 ^ B ^ (B<<<13) ^ (B<<<23).
  - Shift window: K0←K1, K1←K2, K2←K3, K3←rk.
- Round-key packing:
  - Encryption: `RK_o` ← {`RK_o`[991:0], rk}, so rk0 ends in [1023:992] and rk31 in [31:0].
  - Decryption: `RK_o` ← {rk, `RK_o`[1023:32]}, so rk0 ends in [31:0].
- CK constants: byte j of CKi = ((4i+j)·7) mod 256, with byte 0 as the MSB.
- At counter=31: state→DONE, `RK_VALID_o`←1.
- RUN: `BUSY_o`=1 and `KEY_VALID_i` is ignored (not queued).
- DONE: `RK_o` is held indefinitely. A new accepted request drops `RK_VALID_o` at the acceptance edge and restarts.
- `KEY_i` and `DEC_i` are don't-care except on the acceptance edge.
- Reset asserted mid-RUN: immediate return to reset values. No partial key is ever flagged valid.

## Timing
- Request sampled at edge N. `BUSY_o`=1 after edge N.
- Rounds are computed on edges N+1..N+32.
- After edge N+32: `RK_VALID_o`=1, `BUSY_o`=0.
- Latency: 32 cycles from acceptance to valid.
- Throughput: one key per 33 cycles. Back-to-back is allowed, because a request held high in DONE is accepted on the first DONE edge.
- All outputs are registered. Combinational path per cycle: one 32-bit XOR-3, 4 S-boxes, one XOR-4 — comfortably inside one cycle.
- Downstream `decenc` must only latch `RK_o` while `RK_VALID_o`=1.

## Structure
- Shared package `sm4_pkg` holds:
  - the 256-entry S-box table and a `sm4_sbox32` function, shared with `decenc`;
  - the FK constants;
  - the CK generation function, or a 32-entry CK table;
  - a rotate-left helper.
- One sub-module is natural: `sm4_tprime`, the combinational T′ transform (Sbox + L′).
- Top file holds the FSM, counter, K window and RK shift register.

## Test plan
- Reset, then key 0123456789ABCDEFFEDCBA9876543210 with `DEC_i`=0:
  - `RK_VALID_o` rises exactly 32 cycles after acceptance.
  - `RK_o` = f12186f941662b61…29349601cf72e59124a012 (rk0=F12186F9 at MSB, rk31=9124A012 at LSB).
- Same key with `DEC_i`=1:
  - `RK_o`[31:0]=F12186F9, `RK_o`[1023:992]=9124A012; full value is word-reversed relative to the encryption case.
- Chain to `decenc`:
  - Encrypt 0123456789ABCDEFFEDCBA9876543210 → `DAT_o` = 681EDF34D206965E86B3E94F536E4246.
  - Decryption mode with that ciphertext → recovers the plaintext.
- Pulse `KEY_VALID_i` with a different key at cycles 5 and 20 of RUN:
  - Both pulses are ignored; the result matches the original key; `BUSY_o`=1 throughout.
- Assert `RST_N_i` low at round 17:
  - All outputs are 0 asynchronously.
  - A new request after release gives correct keys with full 32-cycle latency.
- `KEY_VALID_i` held high continuously:
  - Recurring 33-cycle period.
  - `RK_VALID_o` high for exactly one cycle per period, each time with the correct `RK_o`.
